// File: rtl/heatmap_reader.sv
`default_nettype none
// ============================================================================
// Module   : heatmap_reader
// Purpose  : Display-side reader for the double-banked tactile heatmap frame
//            buffer. It maps the raster position to a sensor cell at the
//            latched zoom, issues the BRAM read, and returns the cell sample
//            with raster timing delayed to match. It also swaps the displayed
//            bank with the scanner, but only at frame boundaries.
// Ports    :
//   clk_in        pixel clock
//   rst_n_in      synchronous active-low reset
//   scale_in      zoom select (00=1x, 01=16x, 10=32x, 11=64x pixels per cell)
//   hcount_in     raster x         vcount_in    raster y
//   hsync_in      raster hsync     vsync_in     raster vsync
//   blank_in      raster blanking
//   new_frame_in  single-cycle frame-start pulse
//   swap_req_in   single-cycle pulse from the scanner: back bank complete
//   rd_addr_out   BRAM read address {bank, row*SW_WIRE_CNT+col}
//   rd_data_in    BRAM read data (valid RAM_LATENCY cycles after the address)
//   hcount_out / vcount_out / hsync_out / vsync_out / blank_out
//                 raster signals delayed by the pipeline latency
//   data_out      cell sample, 0 outside the heatmap
//   in_region_out pixel lies inside the scaled heatmap
//   bank_out      bank currently displayed (status, not pipeline-delayed)
//   swap_ack_out  single-cycle pulse when the displayed bank changes
// Revision : 1.0  initial release
// ============================================================================
module heatmap_reader #(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int RAM_LATENCY = 2,
  parameter int AW          = $clog2(SW_WIRE_CNT*RD_WIRE_CNT)+1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [1:0]    scale_in,
  input  logic [10:0]   hcount_in,
  input  logic [9:0]    vcount_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          blank_in,
  input  logic          new_frame_in,
  input  logic          swap_req_in,
  output logic [AW-1:0] rd_addr_out,
  input  logic [11:0]   rd_data_in,
  output logic [10:0]   hcount_out,
  output logic [9:0]    vcount_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          blank_out,
  output logic [11:0]   data_out,
  output logic          in_region_out,
  output logic          bank_out,
  output logic          swap_ack_out
);

  // Latency from input sample to outputs: address register, BRAM, output
  // register. The delay line holds c_lat-1 stages; the output register is
  // the last one.
  localparam int c_lat    = RAM_LATENCY + 2;
  localparam int c_stages = c_lat - 1;
  localparam int c_iw     = AW - 1;

  typedef struct packed {
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        in_region;
  } pix_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_t;

  swap_state_t r_state;
  logic        r_bank;
  logic        r_ack;
  logic [1:0]  r_scale;

  logic [1:0]      w_scale;
  logic [2:0]      w_shift;
  logic [10:0]     w_col;
  logic [9:0]      w_row;
  logic            w_in_region;
  logic [c_iw-1:0] w_cell;
  logic            w_swap;
  logic            w_bank_next;

  logic [AW-1:0] r_addr;
  pix_t          r_dly [c_stages];
  pix_t          r_out;
  logic [11:0]   r_data;

  // The new scale and bank both take effect for the pixel sampled on the
  // new_frame_in edge itself, so the first pixel of a frame is consistent.
  always_comb begin
    w_scale = new_frame_in ? scale_in : r_scale;
    case (w_scale)
      2'b00:   w_shift = 3'd0;
      2'b01:   w_shift = 3'd4;
      2'b10:   w_shift = 3'd5;
      default: w_shift = 3'd6;
    endcase
  end

  assign w_col       = hcount_in >> w_shift;
  assign w_row       = vcount_in >> w_shift;
  assign w_in_region = (32'(w_col) < 32'(SW_WIRE_CNT)) &&
                       (32'(w_row) < 32'(RD_WIRE_CNT));

  // Truncation to c_iw bits is safe: inside the region row*SW+col < SW*RD,
  // and outside it the field is forced to zero.
  assign w_cell = w_in_region ?
                  (c_iw'(w_row) * c_iw'(SW_WIRE_CNT) + c_iw'(w_col)) : '0;

  assign w_swap      = new_frame_in && ((r_state == ST_PENDING) || swap_req_in);
  assign w_bank_next = r_bank ^ w_swap;

  // Bank swap FSM plus scale latch.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_bank  <= 1'b0;
      r_ack   <= 1'b0;
      r_scale <= 2'b00;
    end else begin
      r_ack <= 1'b0;
      if (new_frame_in) begin
        r_scale <= scale_in;
      end
      case (r_state)
        ST_IDLE: begin
          if (swap_req_in && new_frame_in) begin
            r_bank <= ~r_bank;
            r_ack  <= 1'b1;
          end else if (swap_req_in) begin
            r_state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          // Further requests here are absorbed into the one pending swap.
          if (new_frame_in) begin
            r_bank  <= ~r_bank;
            r_ack   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Address register, raster delay line and output register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_addr <= '0;
      for (int i = 0; i < c_stages; i++) begin
        r_dly[i] <= '0;
      end
      r_out  <= '0;
      r_data <= '0;
    end else begin
      r_addr   <= {w_bank_next, w_cell};
      r_dly[0] <= '{hcount:    hcount_in,
                    vcount:    vcount_in,
                    hsync:     hsync_in,
                    vsync:     vsync_in,
                    blank:     blank_in,
                    in_region: w_in_region};
      for (int i = 1; i < c_stages; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
      // The last delay stage lines up with the BRAM data for that pixel.
      r_out  <= r_dly[c_stages-1];
      r_data <= r_dly[c_stages-1].in_region ? rd_data_in : 12'h000;
    end
  end

  assign rd_addr_out   = r_addr;
  assign hcount_out    = r_out.hcount;
  assign vcount_out    = r_out.vcount;
  assign hsync_out     = r_out.hsync;
  assign vsync_out     = r_out.vsync;
  assign blank_out     = r_out.blank;
  assign in_region_out = r_out.in_region;
  assign data_out      = r_data;
  assign bank_out      = r_bank;
  assign swap_ack_out  = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_heatmap_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_heatmap_reader
// Purpose  : Directed self-checking bench for heatmap_reader, with a
//            two-cycle-latency BRAM model holding a known data pattern.
// Revision : 1.0  initial release
// ============================================================================
module tb_heatmap_reader;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [1:0]  scale_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  logic        new_frame_in, swap_req_in;
  logic [8:0]  rd_addr_out;
  logic [11:0] rd_data_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, blank_out;
  logic [11:0] data_out;
  logic        in_region_out, bank_out, swap_ack_out;

  int checks = 0;
  int errors = 0;

  logic [11:0] mem [0:511];
  logic [11:0] r_m1;

  always #5 clk_in = ~clk_in;

  // BRAM model: address seen after edge k returns data after edge k+2.
  always @(posedge clk_in) begin
    r_m1       <= mem[rd_addr_out];
    rd_data_in <= r_m1;
  end

  heatmap_reader dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .scale_in      (scale_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .blank_in      (blank_in),
    .new_frame_in  (new_frame_in),
    .swap_req_in   (swap_req_in),
    .rd_addr_out   (rd_addr_out),
    .rd_data_in    (rd_data_in),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .blank_out     (blank_out),
    .data_out      (data_out),
    .in_region_out (in_region_out),
    .bank_out      (bank_out),
    .swap_ack_out  (swap_ack_out)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic set_pix(input logic [10:0] h, input logic [9:0] v);
    hcount_in = h;
    vcount_in = v;
  endtask

  // Latch a scale through a one-cycle new_frame pulse, no swap request.
  task automatic frame_pulse(input logic [1:0] s);
    scale_in     = s;
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    set_pix(11'd37, 10'd20);
    hsync_in = 1'b1;
    swap_req_in = 1'b1;
    tick(3);
    swap_req_in = 1'b0;
    hsync_in = 1'b0;
    checks++; if (rd_addr_out !== 9'd0) begin errors++; $display("FAIL reset_addr: got %0h exp 0", rd_addr_out); end
    checks++; if (data_out !== 12'd0) begin errors++; $display("FAIL reset_data: got %0h exp 0", data_out); end
    checks++; if (hcount_out !== 11'd0 || hsync_out !== 1'b0) begin errors++; $display("FAIL reset_raster: got h=%0d hs=%0b exp 0/0", hcount_out, hsync_out); end
    checks++; if (in_region_out !== 1'b0 || bank_out !== 1'b0 || swap_ack_out !== 1'b0) begin errors++; $display("FAIL reset_flags: got reg=%0b bank=%0b ack=%0b exp 0/0/0", in_region_out, bank_out, swap_ack_out); end
    rst_n_in = 1'b1;
  endtask

  task automatic test_scale01;
    set_pix(11'd500, 10'd0);
    frame_pulse(2'b01);
    tick(4);
    // cycle c: target pixel
    set_pix(11'd37, 10'd20);
    hsync_in = 1'b1;
    tick();
    checks++; if (rd_addr_out !== 9'd18) begin errors++; $display("FAIL s01_addr: got %0d exp 18", rd_addr_out); end
    set_pix(11'd0, 10'd0);
    hsync_in = 1'b0; vsync_in = 1'b1; blank_in = 1'b1;
    tick();
    vsync_in = 1'b0; blank_in = 1'b0;
    tick();
    // c+3: still the previous (out-of-region) pixel
    checks++; if (hcount_out !== 11'd500 || in_region_out !== 1'b0 || data_out !== 12'd0 || hsync_out !== 1'b0) begin
      errors++; $display("FAIL s01_early: got h=%0d reg=%0b d=%0h hs=%0b exp 500/0/0/0", hcount_out, in_region_out, data_out, hsync_out); end
    tick();
    // c+4: target pixel emerges
    checks++; if (hcount_out !== 11'd37 || vcount_out !== 10'd20 || in_region_out !== 1'b1) begin
      errors++; $display("FAIL s01_raster: got h=%0d v=%0d reg=%0b exp 37/20/1", hcount_out, vcount_out, in_region_out); end
    checks++; if (data_out !== 12'hABC) begin errors++; $display("FAIL s01_data: got %0h exp abc", data_out); end
    checks++; if (hsync_out !== 1'b1 || vsync_out !== 1'b0) begin errors++; $display("FAIL s01_hsync: got hs=%0b vs=%0b exp 1/0", hsync_out, vsync_out); end
    tick();
    checks++; if (hcount_out !== 11'd0 || data_out !== mem[0] || vsync_out !== 1'b1 || blank_out !== 1'b1 || hsync_out !== 1'b0) begin
      errors++; $display("FAIL s01_next: got h=%0d d=%0h vs=%0b bl=%0b hs=%0b exp 0/%0h/1/1/0", hcount_out, data_out, vsync_out, blank_out, hsync_out, mem[0]); end
  endtask

  task automatic test_scale00;
    set_pix(11'd15, 10'd15);
    frame_pulse(2'b00);
    tick();
    checks++; if (rd_addr_out !== 9'd255) begin errors++; $display("FAIL s00_addr255: got %0d exp 255", rd_addr_out); end
    set_pix(11'd16, 10'd15);
    tick();
    checks++; if (rd_addr_out !== 9'd0) begin errors++; $display("FAIL s00_addr_out: got %0d exp 0", rd_addr_out); end
    tick(2);
    checks++; if (in_region_out !== 1'b1 || data_out !== mem[255] || hcount_out !== 11'd15) begin
      errors++; $display("FAIL s00_edge_in: got reg=%0b d=%0h h=%0d exp 1/%0h/15", in_region_out, data_out, hcount_out, mem[255]); end
    tick();
    // rd_data_in here holds mem[0] (nonzero) and must be masked
    checks++; if (in_region_out !== 1'b0 || data_out !== 12'd0 || hcount_out !== 11'd16) begin
      errors++; $display("FAIL s00_edge_out: got reg=%0b d=%0h h=%0d exp 0/0/16", in_region_out, data_out, hcount_out); end
  endtask

  task automatic test_scale11;
    set_pix(11'd1023, 10'd1023);
    frame_pulse(2'b11);
    tick();
    checks++; if (rd_addr_out !== 9'd255) begin errors++; $display("FAIL s11_addr255: got %0d exp 255", rd_addr_out); end
    set_pix(11'd1024, 10'd1023);
    tick();
    checks++; if (rd_addr_out !== 9'd0) begin errors++; $display("FAIL s11_addr_out: got %0d exp 0", rd_addr_out); end
    tick(2);
    checks++; if (in_region_out !== 1'b1 || data_out !== mem[255]) begin errors++; $display("FAIL s11_in: got reg=%0b d=%0h exp 1/%0h", in_region_out, data_out, mem[255]); end
    tick();
    checks++; if (in_region_out !== 1'b0 || data_out !== 12'd0) begin errors++; $display("FAIL s11_out: got reg=%0b d=%0h exp 0/0", in_region_out, data_out); end
  endtask

  task automatic test_bank_swap;
    set_pix(11'd0, 10'd0);
    swap_req_in = 1'b1;
    tick();
    swap_req_in = 1'b0;
    checks++; if (bank_out !== 1'b0 || swap_ack_out !== 1'b0 || rd_addr_out !== 9'h000) begin
      errors++; $display("FAIL swap_midframe: got bank=%0b ack=%0b a=%0h exp 0/0/0", bank_out, swap_ack_out, rd_addr_out); end
    tick(3);
    checks++; if (bank_out !== 1'b0) begin errors++; $display("FAIL swap_hold: got %0b exp 0", bank_out); end
    frame_pulse(2'b11);
    checks++; if (bank_out !== 1'b1 || swap_ack_out !== 1'b1 || rd_addr_out !== 9'h100) begin
      errors++; $display("FAIL swap_frame: got bank=%0b ack=%0b a=%0h exp 1/1/100", bank_out, swap_ack_out, rd_addr_out); end
    tick();
    checks++; if (swap_ack_out !== 1'b0 || bank_out !== 1'b1 || rd_addr_out !== 9'h100) begin
      errors++; $display("FAIL swap_ack_pulse: got ack=%0b bank=%0b a=%0h exp 0/1/100", swap_ack_out, bank_out, rd_addr_out); end
  endtask

  task automatic test_multi_req;
    for (int k = 0; k < 3; k++) begin
      swap_req_in = 1'b1;
      tick();
      swap_req_in = 1'b0;
      tick();
    end
    checks++; if (bank_out !== 1'b1) begin errors++; $display("FAIL multi_hold: got %0b exp 1", bank_out); end
    frame_pulse(2'b11);
    checks++; if (bank_out !== 1'b0 || swap_ack_out !== 1'b1) begin errors++; $display("FAIL multi_swap: got bank=%0b ack=%0b exp 0/1", bank_out, swap_ack_out); end
    tick();
    frame_pulse(2'b11);
    checks++; if (bank_out !== 1'b0 || swap_ack_out !== 1'b0) begin errors++; $display("FAIL multi_once: got bank=%0b ack=%0b exp 0/0", bank_out, swap_ack_out); end
  endtask

  task automatic test_coincident;
    swap_req_in  = 1'b1;
    new_frame_in = 1'b1;
    tick();
    swap_req_in  = 1'b0;
    new_frame_in = 1'b0;
    checks++; if (bank_out !== 1'b1 || swap_ack_out !== 1'b1 || rd_addr_out !== 9'h100) begin
      errors++; $display("FAIL coincident: got bank=%0b ack=%0b a=%0h exp 1/1/100", bank_out, swap_ack_out, rd_addr_out); end
    tick();
    checks++; if (swap_ack_out !== 1'b0 || bank_out !== 1'b1) begin errors++; $display("FAIL coincident_after: got ack=%0b bank=%0b exp 0/1", swap_ack_out, bank_out); end
  endtask

  task automatic test_scale_change;
    set_pix(11'd64, 10'd0);
    frame_pulse(2'b01);
    scale_in = 2'b10;
    tick();
    checks++; if (rd_addr_out !== 9'h104) begin errors++; $display("FAIL scale_mid1: got %0h exp 104", rd_addr_out); end
    tick();
    checks++; if (rd_addr_out !== 9'h104) begin errors++; $display("FAIL scale_mid2: got %0h exp 104", rd_addr_out); end
    frame_pulse(2'b10);
    tick();
    checks++; if (rd_addr_out !== 9'h102) begin errors++; $display("FAIL scale_new: got %0h exp 102", rd_addr_out); end
  endtask

  task automatic test_reset_mid;
    set_pix(11'd64, 10'd0);
    hsync_in = 1'b1;
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    hsync_in = 1'b0;
    checks++; if (rd_addr_out !== 9'd0 || data_out !== 12'd0 || hcount_out !== 11'd0 || in_region_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_out: got a=%0h d=%0h h=%0d reg=%0b exp 0/0/0/0", rd_addr_out, data_out, hcount_out, in_region_out); end
    checks++; if (bank_out !== 1'b0 || swap_ack_out !== 1'b0) begin errors++; $display("FAIL rstmid_bank: got bank=%0b ack=%0b exp 0/0", bank_out, swap_ack_out); end
    set_pix(11'd5, 10'd1);
    tick();
    // scale back to 1x and bank 0: row 1 col 5
    checks++; if (rd_addr_out !== 9'd21) begin errors++; $display("FAIL rstmid_addr: got %0d exp 21", rd_addr_out); end
    tick(2);
    checks++; if (hcount_out !== 11'd0 || in_region_out !== 1'b0) begin errors++; $display("FAIL rstmid_early: got h=%0d reg=%0b exp 0/0", hcount_out, in_region_out); end
    tick();
    checks++; if (hcount_out !== 11'd5 || in_region_out !== 1'b1 || data_out !== mem[21]) begin
      errors++; $display("FAIL rstmid_resume: got h=%0d reg=%0b d=%0h exp 5/1/%0h", hcount_out, in_region_out, data_out, mem[21]); end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) begin
      mem[a] = 12'(a * 37 + 5);
    end
    mem[18] = 12'hABC;

    rst_n_in = 1'b0; scale_in = 2'b00;
    hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
    new_frame_in = 1'b0; swap_req_in = 1'b0;

    test_reset();
    test_scale01();
    test_scale00();
    test_scale11();
    test_bank_swap();
    test_multi_req();
    test_coincident();
    test_scale_change();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
